rgb565_to_hsv: RTL and testbench



---
 rtl/rgb565_to_hsv_pkg.sv | 28 ++
 rtl/rgb565_to_hsv_seq_divider.sv | 66 ++++++
 rtl/rgb565_to_hsv.sv | 162 ++++++++++++++++
 tb/tb_rgb565_to_hsv.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb565_to_hsv_pkg.sv
// rtl/rgb565_to_hsv_pkg.sv - shared constants and types for the RGB565 to HSV converter
// Contents: hue sector constants, FSM state enum, max-channel selector, divider step count.
package rgb565_to_hsv_pkg;

    // Hue is coded with 32 codes per 60 degree sector; 192 codes per turn.
    localparam logic [11:0] HUE_SECTOR = 12'd32;
    localparam logic [7:0]  HUE_G      = 8'd64;
    localparam logic [7:0]  HUE_B      = 8'd128;
    localparam logic [7:0]  HUE_WRAP   = 8'd192;

    // One quotient bit per cycle for a 12-bit dividend.
    localparam logic [3:0]  DIV_STEPS  = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MINMAX,
        ST_DIV,
        ST_DONE
    } state_t;

    // Which channel holds the maximum (ties resolved r, then g, then b).
    typedef enum logic [1:0] {
        SEC_R,
        SEC_G,
        SEC_B
    } sector_t;

endpackage

// File: rtl/rgb565_to_hsv_seq_divider.sv
// rtl/rgb565_to_hsv_seq_divider.sv - 12-bit by 6-bit unsigned restoring divider, one bit per cycle
// Ports:
//   clk, rst       : clock, asynchronous active-low reset (clears all state)
//   start          : load dividend/divisor and begin; divisor must be nonzero
//   dividend       : 12-bit numerator
//   divisor        : 6-bit denominator
//   quotient       : low 6 bits of the quotient (callers never exceed 63)
//   done           : high during the cycle whose closing edge writes the last quotient bit
module seq_divider
    import rgb565_to_hsv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] dividend,
    input  logic [5:0]  divisor,
    output logic [5:0]  quotient,
    output logic        done
);

    // quo starts as the dividend and is shifted left, with quotient bits
    // entering at the bottom as dividend bits leave at the top.
    logic [11:0] quo;
    logic [5:0]  rem;
    logic [5:0]  dsr;
    logic [3:0]  cnt;
    logic        busy;
    logic [6:0]  trial;
    logic [5:0]  diff;

    assign trial = {rem, quo[11]};
    // When trial >= dsr the true difference is below dsr, so 6 bits suffice.
    assign diff  = trial[5:0] - dsr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo  <= '0;
            rem  <= '0;
            dsr  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            quo  <= dividend;
            rem  <= '0;
            dsr  <= divisor;
            cnt  <= DIV_STEPS;
            busy <= 1'b1;
        end else if (busy) begin
            if (trial >= {1'b0, dsr}) begin
                rem <= diff;
                quo <= {quo[10:0], 1'b1};
            end else begin
                rem <= trial[5:0];
                quo <= {quo[10:0], 1'b0};
            end
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                busy <= 1'b0;
            end
        end
    end

    assign done     = busy && (cnt == 4'd1);
    assign quotient = quo[5:0];

endmodule

// File: rtl/rgb565_to_hsv.sv
// rtl/rgb565_to_hsv.sv - RGB565 pixel to 8/6/6-bit HSV, fixed 15-cycle multi-cycle pipeline
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   r, g, b        : 5/6/5-bit pixel, sampled on the edge where in_valid is high in IDLE
//   in_valid       : start strobe; ignored while a conversion is in flight
//   h              : hue 0..191, 32 codes per 60 degree sector
//   s, v           : saturation and value, 0..63
//   out_valid      : one-cycle pulse when h/s/v update
module rgb565_to_hsv
    import rgb565_to_hsv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] r,
    input  logic [5:0] g,
    input  logic [4:0] b,
    input  logic       in_valid,
    output logic [7:0] h,
    output logic [5:0] s,
    output logic [5:0] v,
    output logic       out_valid
);

    state_t     state;
    logic [5:0] r6, g6, b6;

    sector_t    sel;
    logic [5:0] mx, mn, dl;
    logic       hue_pos;
    logic [5:0] hue_mag;
    logic [5:0] sat_q, hue_q;
    logic       sat_done, hue_done;
    logic [7:0] hue_res;
    logic       div_start;

    // The captured channels stay stable for the whole conversion, so the
    // min/max network is purely combinational on them.
    always_comb begin
        sel = SEC_R;
        mx  = r6;
        if (r6 >= g6 && r6 >= b6) begin
            sel = SEC_R;
            mx  = r6;
        end else if (g6 >= b6) begin
            sel = SEC_G;
            mx  = g6;
        end else begin
            sel = SEC_B;
            mx  = b6;
        end
        mn = r6;
        if (g6 < mn) mn = g6;
        if (b6 < mn) mn = b6;
        dl = mx - mn;
    end

    // Signed offset from the sector centre, kept as sign + magnitude.
    always_comb begin
        hue_pos = 1'b1;
        hue_mag = '0;
        case (sel)
            SEC_R: begin
                hue_pos = (g6 >= b6);
                hue_mag = hue_pos ? (g6 - b6) : (b6 - g6);
            end
            SEC_G: begin
                hue_pos = (b6 >= r6);
                hue_mag = hue_pos ? (b6 - r6) : (r6 - b6);
            end
            SEC_B: begin
                hue_pos = (r6 >= g6);
                hue_mag = hue_pos ? (r6 - g6) : (g6 - r6);
            end
            default: begin
                hue_pos = 1'b1;
                hue_mag = '0;
            end
        endcase
    end

    assign div_start = (state == ST_MINMAX);

    // Zero divisors are replaced by 1; those results are discarded below.
    seq_divider u_sat_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend ({6'd0, dl} * 12'd63),
        .divisor  ((mx == 6'd0) ? 6'd1 : mx),
        .quotient (sat_q),
        .done     (sat_done)
    );

    seq_divider u_hue_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend ({6'd0, hue_mag} * HUE_SECTOR),
        .divisor  ((dl == 6'd0) ? 6'd1 : dl),
        .quotient (hue_q),
        .done     (hue_done)
    );

    always_comb begin
        hue_res = '0;
        if (dl != 6'd0) begin
            case (sel)
                // Red sector straddles the wrap point; a zero negative
                // offset would give 192, which folds back to 0.
                SEC_R:   hue_res = hue_pos ? {2'b00, hue_q}
                                 : ((hue_q == 6'd0) ? 8'd0 : HUE_WRAP - {2'b00, hue_q});
                SEC_G:   hue_res = hue_pos ? HUE_G + {2'b00, hue_q} : HUE_G - {2'b00, hue_q};
                SEC_B:   hue_res = hue_pos ? HUE_B + {2'b00, hue_q} : HUE_B - {2'b00, hue_q};
                default: hue_res = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            r6        <= '0;
            g6        <= '0;
            b6        <= '0;
            h         <= '0;
            s         <= '0;
            v         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r6    <= {r, r[4]};
                        g6    <= g;
                        b6    <= {b, b[4]};
                        state <= ST_MINMAX;
                    end
                end
                ST_MINMAX: begin
                    state <= ST_DIV;
                end
                ST_DIV: begin
                    if (sat_done && hue_done) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    h         <= hue_res;
                    s         <= (mx == 6'd0) ? 6'd0 : sat_q;
                    v         <= mx;
                    out_valid <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb565_to_hsv.sv
// tb/tb_rgb565_to_hsv.sv - self-checking bench for rgb565_to_hsv against an arithmetic reference
module tb_rgb565_to_hsv;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] r = '0;
    logic [5:0] g = '0;
    logic [4:0] b = '0;
    logic       in_valid = 1'b0;
    logic [7:0] h;
    logic [5:0] s;
    logic [5:0] v;
    logic       out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rgb565_to_hsv dut (
        .clk       (clk),
        .rst       (rst),
        .r         (r),
        .g         (g),
        .b         (b),
        .in_valid  (in_valid),
        .h         (h),
        .s         (s),
        .v         (v),
        .out_valid (out_valid)
    );

    // Reference: colour rules evaluated with plain integer arithmetic.
    function automatic void ref_hsv(input int ri, input int gi, input int bi,
                                    output int eh, output int es, output int ev);
        int r6, g6, b6, mx, mn, d;
        r6 = ri * 2 + ri / 16;
        g6 = gi;
        b6 = bi * 2 + bi / 16;
        mn = (r6 < g6) ? r6 : g6;
        mn = (mn < b6) ? mn : b6;
        if (r6 >= g6 && r6 >= b6) mx = r6;
        else if (g6 >= b6)        mx = g6;
        else                      mx = b6;
        d  = mx - mn;
        ev = mx;
        es = (mx == 0) ? 0 : (d * 63) / mx;
        if (d == 0)
            eh = 0;
        else if (r6 >= g6 && r6 >= b6)
            eh = (g6 >= b6) ? (32 * (g6 - b6)) / d : (192 - (32 * (b6 - g6)) / d) % 192;
        else if (g6 >= b6)
            eh = (b6 >= r6) ? 64 + (32 * (b6 - r6)) / d : 64 - (32 * (r6 - b6)) / d;
        else
            eh = (r6 >= g6) ? 128 + (32 * (r6 - g6)) / d : 128 - (32 * (g6 - r6)) / d;
    endfunction

    // Strobe one pixel, then wait (bounded) for the result. lat counts
    // negedges after the sampling edge; -1 means no result arrived.
    task automatic convert(input int ri, input int gi, input int bi,
                           output int lat, output int oh, output int os, output int ov,
                           output logic after);
        @(posedge clk); #1;
        r = 5'(ri); g = 6'(gi); b = 5'(bi);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        oh = int'(h); os = int'(s); ov = int'(v);
        @(negedge clk);
        after = out_valid;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (h !== 8'd0)        begin n_fail++; $display("FAIL reset_h got %0d want 0", h); end
        n_checks++; if (s !== 6'd0)        begin n_fail++; $display("FAIL reset_s got %0d want 0", s); end
        n_checks++; if (v !== 6'd0)        begin n_fail++; $display("FAIL reset_v got %0d want 0", v); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed();
        int tr[8] = '{15, 15, 15,  0, 31, 0, 31, 31};
        int tg[8] = '{ 0, 25,  0, 63, 63, 0,  1, 63};
        int tb[8] = '{ 0,  0, 10,  0, 31, 0,  1,  0};
        int th[8] = '{ 0, 26,171, 64,  0, 0,  0, 32};
        int ts[8] = '{63, 63, 63, 63,  0, 0, 62, 63};
        int tv[8] = '{30, 30, 30, 63, 63, 0, 63, 63};
        int lat, oh, os, ov;
        logic after;
        for (int i = 0; i < 8; i++) begin
            convert(tr[i], tg[i], tb[i], lat, oh, os, ov, after);
            n_checks++; if (lat !== 15)    begin n_fail++; $display("FAIL dir%0d_latency got %0d want 15", i, lat); end
            n_checks++; if (oh !== th[i])  begin n_fail++; $display("FAIL dir%0d_h got %0d want %0d", i, oh, th[i]); end
            n_checks++; if (os !== ts[i])  begin n_fail++; $display("FAIL dir%0d_s got %0d want %0d", i, os, ts[i]); end
            n_checks++; if (ov !== tv[i])  begin n_fail++; $display("FAIL dir%0d_v got %0d want %0d", i, ov, tv[i]); end
            n_checks++; if (after !== 1'b0) begin n_fail++; $display("FAIL dir%0d_pulse_width got %0b want 0", i, after); end
        end
    endtask

    task automatic test_random();
        int ri, gi, bi, eh, es, ev, lat, oh, os, ov;
        logic after;
        for (int i = 0; i < 40; i++) begin
            ri = int'($urandom_range(31));
            gi = int'($urandom_range(63));
            bi = int'($urandom_range(31));
            ref_hsv(ri, gi, bi, eh, es, ev);
            convert(ri, gi, bi, lat, oh, os, ov, after);
            n_checks++; if (lat !== 15) begin n_fail++; $display("FAIL rnd_latency rgb=%0d,%0d,%0d got %0d want 15", ri, gi, bi, lat); end
            n_checks++; if (oh !== eh)  begin n_fail++; $display("FAIL rnd_h rgb=%0d,%0d,%0d got %0d want %0d", ri, gi, bi, oh, eh); end
            n_checks++; if (os !== es)  begin n_fail++; $display("FAIL rnd_s rgb=%0d,%0d,%0d got %0d want %0d", ri, gi, bi, os, es); end
            n_checks++; if (ov !== ev)  begin n_fail++; $display("FAIL rnd_v rgb=%0d,%0d,%0d got %0d want %0d", ri, gi, bi, ov, ev); end
        end
    endtask

    task automatic test_ignore_second();
        int pulses = 0;
        int first_at = -1;
        int oh = -1, os = -1, ov = -1;
        @(posedge clk); #1;
        r = 5'd15; g = 6'd25; b = 5'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        r = 5'd0; g = 6'd63; b = 5'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int c = 6; c <= 50; c++) begin
            @(negedge clk);
            if (out_valid) begin
                pulses++;
                if (first_at < 0) begin
                    first_at = c;
                    oh = int'(h); os = int'(s); ov = int'(v);
                end
            end
        end
        n_checks++; if (pulses !== 1)   begin n_fail++; $display("FAIL ignore_pulse_count got %0d want 1", pulses); end
        n_checks++; if (first_at !== 15) begin n_fail++; $display("FAIL ignore_latency got %0d want 15", first_at); end
        n_checks++; if (oh !== 26)      begin n_fail++; $display("FAIL ignore_h got %0d want 26", oh); end
        n_checks++; if (os !== 63)      begin n_fail++; $display("FAIL ignore_s got %0d want 63", os); end
        n_checks++; if (ov !== 30)      begin n_fail++; $display("FAIL ignore_v got %0d want 30", ov); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int ri, gi, bi, eh, es, ev, lat, oh, os, ov;
        logic after;
        @(posedge clk); #1;
        r = 5'd15; g = 6'd0; b = 5'd10;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_checks++; if (h !== 8'd0)        begin n_fail++; $display("FAIL midrst_h got %0d want 0", h); end
        n_checks++; if (s !== 6'd0)        begin n_fail++; $display("FAIL midrst_s got %0d want 0", s); end
        n_checks++; if (v !== 6'd0)        begin n_fail++; $display("FAIL midrst_v got %0d want 0", v); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %0b want 0", out_valid); end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL midrst_spurious_pulses got %0d want 0", pulses); end
        ri = int'($urandom_range(31));
        gi = int'($urandom_range(63));
        bi = int'($urandom_range(31));
        ref_hsv(ri, gi, bi, eh, es, ev);
        convert(ri, gi, bi, lat, oh, os, ov, after);
        n_checks++; if (lat !== 15) begin n_fail++; $display("FAIL midrst_next_latency got %0d want 15", lat); end
        n_checks++; if (oh !== eh)  begin n_fail++; $display("FAIL midrst_next_h got %0d want %0d", oh, eh); end
        n_checks++; if (os !== es)  begin n_fail++; $display("FAIL midrst_next_s got %0d want %0d", os, es); end
        n_checks++; if (ov !== ev)  begin n_fail++; $display("FAIL midrst_next_v got %0d want %0d", ov, ev); end
    endtask

    task automatic test_back_to_back();
        int pr[4], pg[4], pb[4];
        int k = 0;
        int eh, es, ev;
        logic [7:0] hold_h;
        logic [5:0] hold_s, hold_v;
        for (int i = 0; i < 4; i++) begin
            pr[i] = int'($urandom_range(31));
            pg[i] = int'($urandom_range(63));
            pb[i] = int'($urandom_range(31));
        end
        @(posedge clk); #1;
        r = 5'(pr[0]); g = 6'(pg[0]); b = 5'(pb[0]);
        in_valid = 1'b1;
        @(posedge clk);
        hold_h = h; hold_s = s; hold_v = v;
        for (int c = 1; c <= 100 && k < 4; c++) begin
            @(negedge clk);
            if (out_valid) begin
                ref_hsv(pr[k], pg[k], pb[k], eh, es, ev);
                n_checks++; if (c !== 15 * (k + 1)) begin n_fail++; $display("FAIL b2b%0d_timing got %0d want %0d", k, c, 15 * (k + 1)); end
                n_checks++; if (int'(h) !== eh) begin n_fail++; $display("FAIL b2b%0d_h got %0d want %0d", k, h, eh); end
                n_checks++; if (int'(s) !== es) begin n_fail++; $display("FAIL b2b%0d_s got %0d want %0d", k, s, es); end
                n_checks++; if (int'(v) !== ev) begin n_fail++; $display("FAIL b2b%0d_v got %0d want %0d", k, v, ev); end
                hold_h = h; hold_s = s; hold_v = v;
                k++;
                if (k < 4) begin
                    r = 5'(pr[k]); g = 6'(pg[k]); b = 5'(pb[k]);
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                n_checks++;
                if (h !== hold_h || s !== hold_s || v !== hold_v) begin
                    n_fail++;
                    $display("FAIL b2b_hold cycle %0d got %0d/%0d/%0d want %0d/%0d/%0d",
                             c, h, s, v, hold_h, hold_s, hold_v);
                end
            end
        end
        in_valid = 1'b0;
        n_checks++; if (k !== 4) begin n_fail++; $display("FAIL b2b_result_count got %0d want 4", k); end
        repeat (20) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_second();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
